// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch front end: credit-limited request issue, PC pairing, instruction buffer and redirect squash.
// Optional IFU_RSP_BYPASS_EN: an empty buffer forwards a live response straight to the head outputs.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_addr_i,
  output logic        ireq_valid_o,
  output logic [31:0] ireq_addr_o,
  input  logic        ireq_ready_i,
  input  logic        irsp_valid_i,
  input  logic [31:0] irsp_data_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        stale_q, stale_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;

  logic [31:0] pcq_q [FIFO_DEPTH];
  logic [31:0] pcq_d [FIFO_DEPTH];
  ptr_t        pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

  logic [31:0] fifo_inst_q [FIFO_DEPTH];
  logic [31:0] fifo_inst_d [FIFO_DEPTH];
  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_pc_d   [FIFO_DEPTH];
  ptr_t        fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  cnt_t        fifo_cnt_q, fifo_cnt_d;

  logic [31:0] inst_q, inst_d, pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;

  logic        accept, rsp, rsp_keep, byp;
  logic        consume, pop, push;
  logic        exu_redir, pred_redir, redir;
  logic [31:0] redir_tgt, rsp_pc;
  logic [SW-1:0] credit_sum;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{jump_addr_i[1:0], pred_addr_i[1:0]};

  assign accept    = req_valid_q & ireq_ready_i;
  assign rsp       = irsp_valid_i & (outst_q != '0);
  assign rsp_pc    = pcq_q[pcq_rd_q];
  assign exu_redir = jump_flag_i;
  // A live response is only worth keeping if nothing older is still being squashed.
  assign rsp_keep  = rsp & (drop_q == '0) & ~exu_redir;

`ifdef IFU_RSP_BYPASS_EN
  assign byp          = rsp_keep & (fifo_cnt_q == '0);
  assign inst_valid_o = inst_valid_q | byp;
  assign inst_o       = byp ? irsp_data_i : inst_q;
  assign pc_o         = byp ? rsp_pc      : pc_q;
`else
  assign byp          = 1'b0;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
`endif

  assign consume    = inst_valid_o & ~stall_i & ~exu_redir;
  assign pred_redir = consume & pred_taken_i;
  assign redir      = exu_redir | pred_redir;
  assign redir_tgt  = exu_redir ? {jump_addr_i[31:2], 2'b00} : {pred_addr_i[31:2], 2'b00};
  assign pop        = inst_valid_q & consume;
  assign push       = rsp_keep & ~pred_redir & ~(byp & ~stall_i);

  assign ireq_valid_o = req_valid_q;
  assign ireq_addr_o  = req_addr_q;

  always_comb begin
    pcq_d    = pcq_q;
    pcq_wr_d = pcq_wr_q + ptr_t'(accept);
    pcq_rd_d = pcq_rd_q + ptr_t'(rsp);
    if (accept) pcq_d[pcq_wr_q] = req_addr_q;
    outst_d = outst_q + cnt_t'(accept) - cnt_t'(rsp);

    drop_d = drop_q;
    if (rsp && (drop_q != '0)) drop_d = drop_d - cnt_t'(1);
    if (accept && stale_q)     drop_d = drop_d + cnt_t'(1);
    // Everything still in flight after this cycle belongs to the old path.
    if (redir)                 drop_d = outst_d;

    stale_d = stale_q;
    if (accept) stale_d = 1'b0;
    if (redir && req_valid_q && !accept) stale_d = 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (accept && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redir)              fetch_pc_d = redir_tgt;

    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (push) begin
      fifo_inst_d[fifo_wr_q] = irsp_data_i;
      fifo_pc_d[fifo_wr_q]   = rsp_pc;
    end
    if (redir) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      fifo_wr_d  = fifo_wr_q + ptr_t'(push);
      fifo_rd_d  = fifo_rd_q + ptr_t'(pop);
      fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
    end

    credit_sum = SW'(outst_d) + SW'(fifo_cnt_d);
    if (req_valid_q && !accept) begin
      req_valid_d = 1'b1;
      req_addr_d  = req_addr_q;
    end else begin
      req_valid_d = credit_sum < SW'(FIFO_DEPTH);
      req_addr_d  = fetch_pc_d;
    end

    // Output registers always mirror the buffer head as it will stand after this edge.
    inst_valid_d = fifo_cnt_d != '0;
    inst_d       = inst_q;
    pc_d         = pc_q;
    if (fifo_cnt_d != '0) begin
      inst_d = fifo_inst_d[fifo_rd_d];
      pc_d   = fifo_pc_d[fifo_rd_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_addr_q   <= RESET_PC;
      stale_q      <= 1'b0;
      outst_q      <= '0;
      drop_q       <= '0;
      pcq_wr_q     <= '0;
      pcq_rd_q     <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_cnt_q   <= '0;
      inst_q       <= '0;
      pc_q         <= '0;
      inst_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcq_q[i]       <= '0;
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      stale_q      <= stale_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      pcq_q        <= pcq_d;
      pcq_wr_q     <= pcq_wr_d;
      pcq_rd_q     <= pcq_rd_d;
      fifo_inst_q  <= fifo_inst_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_cnt_q   <= fifo_cnt_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && !redir && fifo_cnt_q == cnt_t'(FIFO_DEPTH)));
      assert (!(accept && !rsp && outst_q == cnt_t'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a latency-configurable memory model plus logs of accepted and consumed PCs.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_addr_i = '0;
  logic        ireq_valid_o;
  logic [31:0] ireq_addr_o;
  logic        ireq_ready_i = 1'b1;
  logic        irsp_valid_i = 1'b0;
  logic [31:0] irsp_data_i = '0;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .stall_i      (stall_i),
    .pred_taken_i (pred_taken_i),
    .pred_addr_i  (pred_addr_i),
    .ireq_valid_o (ireq_valid_o),
    .ireq_addr_o  (ireq_addr_o),
    .ireq_ready_i (ireq_ready_i),
    .irsp_valid_i (irsp_valid_i),
    .irsp_data_i  (irsp_data_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] con_log[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int k, amark, cmark, n;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] getq(input logic [31:0] q[$], input int i);
    if (i < 0 || i >= q.size()) return 32'hxxxx_xxxx;
    return q[i];
  endfunction

  function automatic int count_of(input logic [31:0] q[$], input logic [31:0] v);
    int c = 0;
    foreach (q[i]) if (q[i] === v) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with this cycle's control inputs already set; returns at the next negedge.
  task automatic tick();
    mreq_t e;
    irsp_valid_i = 1'b0;
    irsp_data_i  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      irsp_valid_i = 1'b1;
      irsp_data_i  = mem_data(mq[0].addr);
      void'(mq.pop_front());
    end
    if (ireq_valid_o && ireq_ready_i) begin
      acc_log.push_back(ireq_addr_o);
      e.addr = ireq_addr_o;
      e.due  = cyc + lat;
      mq.push_back(e);
    end
    if (inst_valid_o && !stall_i && !jump_flag_i) begin
      con_log.push_back(pc_o);
      chk("inst_data", inst_o, mem_data(pc_o));
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    irsp_valid_i = 1'b0;
    irsp_data_i  = '0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    jump_flag_i  = 1'b0;
    jump_addr_i  = '0;
    stall_i      = 1'b0;
    pred_taken_i = 1'b0;
    pred_addr_i  = '0;
    ireq_ready_i = 1'b1;
    irsp_valid_i = 1'b0;
    irsp_data_i  = '0;
    #1;
    chk("rst_ireq_valid", 32'(ireq_valid_o), 32'd0);
    chk("rst_ireq_addr", ireq_addr_o, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    mq.delete();
    acc_log.delete();
    con_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("first_req_valid", 32'(ireq_valid_o), 32'd1);
    chk("first_req_addr", ireq_addr_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Straight-line fetch with a 1-cycle memory
    do_reset();
    repeat (20) tick();
    chk("t1_acc0", getq(acc_log, 0), 32'h0);
    chk("t1_acc1", getq(acc_log, 1), 32'h4);
    chk("t1_acc2", getq(acc_log, 2), 32'h8);
    chk("t1_acc3", getq(acc_log, 3), 32'hC);
    chk("t1_con0", getq(con_log, 0), 32'h0);
    chk("t1_con1", getq(con_log, 1), 32'h4);
    chk("t1_con2", getq(con_log, 2), 32'h8);

    // Memory not ready: request held
    do_reset();
    ireq_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(ireq_valid_o), 32'd1);
      chk("t2_hold_addr", ireq_addr_o, 32'h0);
      chk("t2_no_head", 32'(inst_valid_o), 32'd0);
    end
    chk("t2_no_accept", acc_log.size(), 32'd0);
    ireq_ready_i = 1'b1;
    repeat (10) tick();
    chk("t2_con0", getq(con_log, 0), 32'h0);
    chk("t2_con1", getq(con_log, 1), 32'h4);

    // Stall fills the buffer
    do_reset();
    for (int i = 0; i < 10 && !inst_valid_o; i++) tick();
    chk("t3_head_valid", 32'(inst_valid_o), 32'd1);
    stall_i = 1'b1;
    repeat (4) tick();
    chk("t3_full_no_req", 32'(ireq_valid_o), 32'd0);
    chk("t3_pc_frozen", pc_o, 32'h0);
    chk("t3_head_kept", 32'(inst_valid_o), 32'd1);
    chk("t3_none_consumed", con_log.size(), 32'd0);
    stall_i = 1'b0;
    repeat (20) tick();
    chk("t3_con0", getq(con_log, 0), 32'h0);
    chk("t3_con1", getq(con_log, 1), 32'h4);
    chk("t3_con2", getq(con_log, 2), 32'h8);
    chk("t3_con3", getq(con_log, 3), 32'hC);

    // Predicted-taken head at 0x10 with a slower memory
    lat = 2;
    do_reset();
    for (int i = 0; i < 60 && !(inst_valid_o && pc_o == 32'h10); i++) tick();
    chk("t4_head10", 32'(inst_valid_o && pc_o == 32'h10), 32'd1);
    pred_taken_i = 1'b1;
    pred_addr_i  = 32'h100;
    tick();
    pred_taken_i = 1'b0;
    pred_addr_i  = '0;
    repeat (25) tick();
    k = -1;
    foreach (con_log[i]) if (k < 0 && con_log[i] === 32'h10) k = i;
    chk("t4_after10", getq(con_log, k + 1), 32'h100);
    chk("t4_after100", getq(con_log, k + 2), 32'h104);
    n = count_of(con_log, 32'h14);
    chk("t4_no14", n, 32'd0);
    lat = 1;

    // EXU redirect with stall and a full buffer; target low bits ignored
    do_reset();
    stall_i = 1'b1;
    repeat (8) tick();
    chk("t5_full_no_req", 32'(ireq_valid_o), 32'd0);
    chk("t5_head_valid", 32'(inst_valid_o), 32'd1);
    chk("t5_head_pc", pc_o, 32'h0);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h202;
    tick();
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    chk("t5_flushed", 32'(inst_valid_o), 32'd0);
    stall_i = 1'b0;
    repeat (20) tick();
    chk("t5_con0", getq(con_log, 0), 32'h200);
    chk("t5_con1", getq(con_log, 1), 32'h204);

    // Redirect while the 0x40 request is pending unaccepted
    do_reset();
    for (int i = 0; i < 60 && !(ireq_valid_o && ireq_addr_o == 32'h40); i++) tick();
    chk("t6_req40", 32'(ireq_valid_o && ireq_addr_o == 32'h40), 32'd1);
    ireq_ready_i = 1'b0;
    jump_flag_i  = 1'b1;
    jump_addr_i  = 32'h303;
    tick();
    jump_flag_i  = 1'b0;
    jump_addr_i  = '0;
    chk("t6_held_valid", 32'(ireq_valid_o), 32'd1);
    chk("t6_held_addr", ireq_addr_o, 32'h40);
    amark = acc_log.size();
    cmark = con_log.size();
    tick();
    chk("t6_still_held", ireq_addr_o, 32'h40);
    ireq_ready_i = 1'b1;
    repeat (20) tick();
    chk("t6_acc_stale", getq(acc_log, amark), 32'h40);
    chk("t6_acc_new", getq(acc_log, amark + 1), 32'h300);
    chk("t6_con0", getq(con_log, cmark), 32'h300);
    chk("t6_con1", getq(con_log, cmark + 1), 32'h304);
    n = count_of(con_log, 32'h40);
    chk("t6_no40", n, 32'd0);

    // Fetch PC wraps at 32 bits
    do_reset();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    repeat (15) tick();
    chk("t7_con0", getq(con_log, 0), 32'hFFFF_FFFC);
    chk("t7_con1", getq(con_log, 1), 32'h0);
    chk("t7_con2", getq(con_log, 2), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
